// File: rtl/ysyx_cmu_redirect_if.sv
// ysyx_cmu_redirect_if
//   Bundles every non-clock/reset signal of the commit-unit redirect
//   sequencer.
//   - master modport: the surrounding pipeline. It drives the commit
//     broadcast, the cache done pulses and the IFU ready, and it observes
//     the recovery outputs.
//   - slave modport: ysyx_cmu_redirect itself.
//   Signal groups:
//     commit broadcast : cmt_valid, cmt_rpc, cmt_cpc, cmt_flush_pipe,
//                        cmt_fence_i, cmt_fence_time, cmt_time_trap, trap_vec
//     D-cache          : dc_drain_req / dc_drain_done
//     I-cache          : ic_inv_req / ic_inv_done
//     IFU              : flush, redirect_valid, redirect_pc, redirect_ready
//     status           : commit_stall, trap_epc, pmu_redirect, pmu_fence_i
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

interface ysyx_cmu_redirect_if #(
  parameter int XLEN = `YSYX_XLEN
);
  logic            cmt_valid;
  logic [XLEN-1:0] cmt_rpc;
  logic [XLEN-1:0] cmt_cpc;
  logic            cmt_flush_pipe;
  logic            cmt_fence_i;
  logic            cmt_fence_time;
  logic            cmt_time_trap;
  logic [XLEN-1:0] trap_vec;

  logic            dc_drain_req;
  logic            dc_drain_done;
  logic            ic_inv_req;
  logic            ic_inv_done;

  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  logic            commit_stall;
  logic [XLEN-1:0] trap_epc;
  logic [XLEN-1:0] pmu_redirect;
  logic [XLEN-1:0] pmu_fence_i;

  modport master (
    output cmt_valid, cmt_rpc, cmt_cpc, cmt_flush_pipe, cmt_fence_i,
           cmt_fence_time, cmt_time_trap, trap_vec,
           dc_drain_done, ic_inv_done, redirect_ready,
    input  dc_drain_req, ic_inv_req, flush, redirect_valid, redirect_pc,
           commit_stall, trap_epc, pmu_redirect, pmu_fence_i
  );

  modport slave (
    input  cmt_valid, cmt_rpc, cmt_cpc, cmt_flush_pipe, cmt_fence_i,
           cmt_fence_time, cmt_time_trap, trap_vec,
           dc_drain_done, ic_inv_done, redirect_ready,
    output dc_drain_req, ic_inv_req, flush, redirect_valid, redirect_pc,
           commit_stall, trap_epc, pmu_redirect, pmu_fence_i
  );
endinterface

// File: rtl/ysyx_cmu_redirect.sv
// ysyx_cmu_redirect
//   Recovery sequencer that sits behind the commit unit. When a retiring
//   instruction (or a pending timer trap) needs the pipeline redirected,
//   it runs the following steps in order:
//     1. a one-cycle flush;
//     2. an optional D-cache drain (fence, fence.i);
//     3. an optional I-cache invalidate (fence.i);
//     4. a redirect that is held toward the IFU until it is accepted.
//   commit_stall stays high for the whole sequence.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   cmu          : ysyx_cmu_redirect_if.slave. It carries the commit
//                  broadcast, the cache handshakes, the IFU redirect,
//                  trap_epc and the two PMU counters.
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

module ysyx_cmu_redirect #(
  parameter int XLEN = `YSYX_XLEN
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_cmu_redirect_if.slave   cmu
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN_DC,
    S_INV_IC,
    S_REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_FLUSH,
    K_FENCE,
    K_FENCEI,
    K_TRAP
  } kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cnt_redirect_q;
  logic [XLEN-1:0] cnt_fence_i_q;

  logic            trigger;
  kind_t           trig_kind;
  logic [XLEN-1:0] trig_target;
  logic            handshake;

  // Event decode, highest priority first. The timer trap is level-sensitive
  // and does not need cmt_valid.
  always_comb begin
    trigger     = 1'b0;
    trig_kind   = K_FLUSH;
    trig_target = cmu.cmt_cpc;
    if (cmu.cmt_time_trap) begin
      trigger     = 1'b1;
      trig_kind   = K_TRAP;
      trig_target = cmu.trap_vec;
    end else if (cmu.cmt_valid) begin
      if (cmu.cmt_fence_i) begin
        trigger   = 1'b1;
        trig_kind = K_FENCEI;
      end else if (cmu.cmt_fence_time) begin
        trigger   = 1'b1;
        trig_kind = K_FENCE;
      end else if (cmu.cmt_flush_pipe) begin
        trigger   = 1'b1;
        trig_kind = K_FLUSH;
      end
    end
  end

  assign handshake = (state_q == S_REDIRECT) && cmu.redirect_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (kind_q == K_FENCEI || kind_q == K_FENCE) state_d = S_DRAIN_DC;
        else                                         state_d = S_REDIRECT;
      end
      S_DRAIN_DC: begin
        if (cmu.dc_drain_done) begin
          state_d = (kind_q == K_FENCEI) ? S_INV_IC : S_REDIRECT;
        end
      end
      S_INV_IC: begin
        if (cmu.ic_inv_done) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (cmu.redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The target, kind and trap EPC are captured only when an event is
  // accepted in IDLE. Anything that retires while busy is wrong-path and
  // is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      kind_q         <= K_FLUSH;
      target_q       <= '0;
      epc_q          <= '0;
      cnt_redirect_q <= '0;
      cnt_fence_i_q  <= '0;
    end else begin
      if (state_q == S_IDLE && trigger) begin
        kind_q   <= trig_kind;
        target_q <= trig_target;
        if (trig_kind == K_TRAP) epc_q <= cmu.cmt_rpc;
      end
      if (handshake) begin
        cnt_redirect_q <= cnt_redirect_q + 1'b1;
        if (kind_q == K_FENCEI) cnt_fence_i_q <= cnt_fence_i_q + 1'b1;
      end
    end
  end

  always_comb begin
    cmu.flush          = (state_q == S_FLUSH);
    cmu.dc_drain_req   = (state_q == S_DRAIN_DC);
    cmu.ic_inv_req     = (state_q == S_INV_IC);
    cmu.redirect_valid = (state_q == S_REDIRECT);
    cmu.redirect_pc    = target_q;
    cmu.commit_stall   = (state_q != S_IDLE);
    cmu.trap_epc       = epc_q;
    cmu.pmu_redirect   = cnt_redirect_q;
    cmu.pmu_fence_i    = cnt_fence_i_q;
  end

endmodule

// File: tb/tb_ysyx_cmu_redirect.sv
// tb_ysyx_cmu_redirect
//   Self-checking scoreboard bench for ysyx_cmu_redirect.
//   - Stimulus pushes the expected redirect of every accepted event.
//   - A negedge monitor pops and compares at each redirect handshake.
//   - Cycle-exact checks cover the directed recovery sequences.
module tb_ysyx_cmu_redirect;
  localparam int XLEN   = 64;
  localparam int KFLUSH = 0;
  localparam int KFENCE = 1;
  localparam int KFI    = 2;
  localparam int KTRAP  = 3;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] epc;
    int          kind;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_cmu_redirect_if #(.XLEN(XLEN)) bus ();

  ysyx_cmu_redirect #(.XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .cmu   (bus.slave)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  logic [63:0] exp_red = '0;
  logic [63:0] exp_fi  = '0;
  bit          pmu_pending = 1'b0;
  bit          auto_resp   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        pmu_pending = 1'b0;
      end else begin
        if (pmu_pending) begin
          check("pmu_redirect", bus.pmu_redirect, exp_red);
          check("pmu_fence_i", bus.pmu_fence_i, exp_fi);
          pmu_pending = 1'b0;
        end
        if (bus.flush)
          check("flush_expected", 64'(exp_q.size() != 0), 64'd1);
        if (bus.dc_drain_req)
          check("drain_kind", 64'(exp_q.size() != 0 &&
                (exp_q[0].kind == KFENCE || exp_q[0].kind == KFI)), 64'd1);
        if (bus.ic_inv_req)
          check("inv_kind", 64'(exp_q.size() != 0 && exp_q[0].kind == KFI), 64'd1);
        if (bus.redirect_valid && bus.redirect_ready) begin
          check("redirect_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("redirect_pc", bus.redirect_pc, e.pc);
            if (e.kind == KTRAP) check("trap_epc", bus.trap_epc, e.epc);
            exp_red = exp_red + 64'd1;
            if (e.kind == KFI) exp_fi = exp_fi + 64'd1;
            pmu_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required completion within time limit");
    $fatal(1);
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    if (auto_resp) begin
      bus.dc_drain_done  = ($urandom_range(0, 2) == 0);
      bus.ic_inv_done    = ($urandom_range(0, 2) == 0);
      bus.redirect_ready = ($urandom_range(0, 1) == 0);
    end
  endtask

  task automatic clear_cmt();
    bus.cmt_valid      = 1'b0;
    bus.cmt_rpc        = '0;
    bus.cmt_cpc        = '0;
    bus.cmt_flush_pipe = 1'b0;
    bus.cmt_fence_i    = 1'b0;
    bus.cmt_fence_time = 1'b0;
    bus.cmt_time_trap  = 1'b0;
  endtask

  task automatic clear_resp();
    bus.dc_drain_done  = 1'b0;
    bus.ic_inv_done    = 1'b0;
    bus.redirect_ready = 1'b0;
  endtask

  // Drives one commit broadcast while the DUT is idle and records what the
  // recovery should produce.
  task automatic drive_event(input bit tt, input bit v, input bit fi, input bit ft,
                             input bit fp, input logic [63:0] rpc,
                             input logic [63:0] cpc, input logic [63:0] tv);
    exp_t e;
    bit   acc;
    bus.cmt_time_trap  = tt;
    bus.cmt_valid      = v;
    bus.cmt_fence_i    = fi;
    bus.cmt_fence_time = ft;
    bus.cmt_flush_pipe = fp;
    bus.cmt_rpc        = rpc;
    bus.cmt_cpc        = cpc;
    bus.trap_vec       = tv;
    acc   = 1'b1;
    e.epc = rpc;
    e.pc  = cpc;
    if (tt) begin
      e.kind = KTRAP;
      e.pc   = tv;
    end else if (v && fi) e.kind = KFI;
    else if (v && ft)     e.kind = KFENCE;
    else if (v && fp)     e.kind = KFLUSH;
    else begin
      e.kind = KFLUSH;
      acc    = 1'b0;
    end
    if (acc) exp_q.push_back(e);
  endtask

  // Steps until the DUT is idle again. Wrong-path broadcasts can optionally
  // be driven while it is busy.
  task automatic wait_idle(input bit garbage);
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (!bus.commit_stall) begin
        done = 1'b1;
      end else begin
        if (garbage) begin
          bus.cmt_time_trap  = ($urandom_range(0, 3) == 0);
          bus.cmt_valid      = $urandom_range(0, 1);
          bus.cmt_fence_i    = $urandom_range(0, 1);
          bus.cmt_fence_time = $urandom_range(0, 1);
          bus.cmt_flush_pipe = $urandom_range(0, 1);
          bus.cmt_rpc        = rnd64();
          bus.cmt_cpc        = rnd64();
          bus.trap_vec       = rnd64();
        end else begin
          clear_cmt();
        end
        tick();
      end
    end
    clear_cmt();
    if (!done) check("idle_timeout", 64'(bus.commit_stall), 64'd0);
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_red = '0;
    exp_fi  = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_cmt();
    clear_resp();
    bus.trap_vec = '0;
    repeat (3) tick();
    reset_model();
    reset = 1'b0;

    // Three redirects so the counter has something to clear.
    auto_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_event(0, 1, 0, 0, 1, rnd64(), rnd64(), '0);
      tick();
      wait_idle(0);
    end
    repeat (3) tick();

    // Reset with every input held high.
    auto_resp = 1'b0;
    bus.cmt_valid = 1'b1; bus.cmt_flush_pipe = 1'b1; bus.cmt_fence_i = 1'b1;
    bus.cmt_fence_time = 1'b1; bus.cmt_time_trap = 1'b1;
    bus.cmt_rpc = '1; bus.cmt_cpc = '1; bus.trap_vec = '1;
    bus.dc_drain_done = 1'b1; bus.ic_inv_done = 1'b1; bus.redirect_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset_model();
    for (int r = 0; r < 2; r++) begin
      check("rst_flush", 64'(bus.flush), 0);
      check("rst_dc_req", 64'(bus.dc_drain_req), 0);
      check("rst_ic_req", 64'(bus.ic_inv_req), 0);
      check("rst_rvalid", 64'(bus.redirect_valid), 0);
      check("rst_rpc", bus.redirect_pc, 0);
      check("rst_stall", 64'(bus.commit_stall), 0);
      check("rst_epc", bus.trap_epc, 0);
      check("rst_pmu_redirect", bus.pmu_redirect, 0);
      check("rst_pmu_fence_i", bus.pmu_fence_i, 0);
      reset = 1'b0;
    end
    clear_cmt();
    clear_resp();
    tick();
    check("post_rst_stall", 64'(bus.commit_stall), 0);

    // Flush with the IFU stalling until T+5.
    drive_event(0, 1, 0, 0, 1, 64'h8000_003c, 64'h8000_0040, '0);
    tick(); clear_cmt();
    check("fp_flush_t1", 64'(bus.flush), 1);
    check("fp_rvalid_t1", 64'(bus.redirect_valid), 0);
    check("fp_stall_t1", 64'(bus.commit_stall), 1);
    for (int t = 2; t <= 5; t++) begin
      tick();
      check("fp_flush_low", 64'(bus.flush), 0);
      check("fp_rvalid", 64'(bus.redirect_valid), 1);
      check("fp_rpc", bus.redirect_pc, 64'h8000_0040);
    end
    bus.redirect_ready = 1'b1;
    tick(); bus.redirect_ready = 1'b0;
    check("fp_stall_t6", 64'(bus.commit_stall), 0);
    check("fp_rvalid_t6", 64'(bus.redirect_valid), 0);
    tick();

    // fence.i: drain done at T+4, invalidate done in its first cycle.
    drive_event(0, 1, 1, 0, 0, 64'h8000_00fc, 64'h8000_0100, '0);
    tick(); clear_cmt();
    check("fi_flush", 64'(bus.flush), 1);
    check("fi_dc_t1", 64'(bus.dc_drain_req), 0);
    check("fi_stall_t1", 64'(bus.commit_stall), 1);
    for (int t = 2; t <= 4; t++) begin
      tick();
      check("fi_dc_req", 64'(bus.dc_drain_req), 1);
      check("fi_stall", 64'(bus.commit_stall), 1);
    end
    bus.dc_drain_done = 1'b1;
    tick(); bus.dc_drain_done = 1'b0;
    check("fi_dc_t5", 64'(bus.dc_drain_req), 0);
    check("fi_ic_t5", 64'(bus.ic_inv_req), 1);
    check("fi_stall_t5", 64'(bus.commit_stall), 1);
    bus.ic_inv_done = 1'b1;
    tick(); bus.ic_inv_done = 1'b0;
    check("fi_ic_t6", 64'(bus.ic_inv_req), 0);
    check("fi_rvalid_t6", 64'(bus.redirect_valid), 1);
    check("fi_rpc", bus.redirect_pc, 64'h8000_0100);
    check("fi_stall_t6", 64'(bus.commit_stall), 1);
    bus.redirect_ready = 1'b1;
    tick(); bus.redirect_ready = 1'b0;
    check("fi_stall_t7", 64'(bus.commit_stall), 0);
    tick();

    // Timer trap together with fence.i: the trap wins, so there is no cache work.
    bus.redirect_ready = 1'b1;
    drive_event(1, 1, 1, 0, 0, 64'h8000_0010, 64'h8000_0200, 64'h8000_1000);
    tick(); clear_cmt();
    check("tr_flush", 64'(bus.flush), 1);
    tick();
    check("tr_rvalid", 64'(bus.redirect_valid), 1);
    check("tr_dc", 64'(bus.dc_drain_req), 0);
    check("tr_rpc", bus.redirect_pc, 64'h8000_1000);
    check("tr_epc", bus.trap_epc, 64'h8000_0010);
    tick(); bus.redirect_ready = 1'b0;
    check("tr_stall", 64'(bus.commit_stall), 0);
    tick();

    // Overlapping wrong-path flush commits, then stray done pulses in IDLE.
    drive_event(0, 1, 0, 0, 1, 64'h0ffc, 64'h1000, '0);
    tick();
    bus.cmt_valid = 1'b1; bus.cmt_flush_pipe = 1'b1; bus.cmt_cpc = 64'h2000;
    tick();
    check("ov_rpc_t2", bus.redirect_pc, 64'h1000);
    tick(); clear_cmt(); bus.redirect_ready = 1'b1;
    check("ov_rpc_t3", bus.redirect_pc, 64'h1000);
    tick(); bus.redirect_ready = 1'b0;
    check("ov_stall", 64'(bus.commit_stall), 0);
    bus.dc_drain_done = 1'b1; bus.ic_inv_done = 1'b1;
    tick(); tick();
    bus.dc_drain_done = 1'b0; bus.ic_inv_done = 1'b0;
    check("stray_stall", 64'(bus.commit_stall), 0);
    check("stray_dc", 64'(bus.dc_drain_req), 0);
    check("stray_ic", 64'(bus.ic_inv_req), 0);
    tick();

    // Reset while draining; a late done pulse must not move the FSM.
    drive_event(0, 1, 0, 1, 0, 64'h2ffc, 64'h3000, '0);
    tick(); clear_cmt();
    tick();
    check("rm_dc_req", 64'(bus.dc_drain_req), 1);
    reset = 1'b1;
    tick();
    reset_model();
    check("rm_dc_after", 64'(bus.dc_drain_req), 0);
    check("rm_stall_after", 64'(bus.commit_stall), 0);
    reset = 1'b0;
    tick(); bus.dc_drain_done = 1'b1;
    tick(); bus.dc_drain_done = 1'b0;
    check("rm_late_done", 64'(bus.commit_stall), 0);
    check("rm_late_dc", 64'(bus.dc_drain_req), 0);
    auto_resp = 1'b1;
    drive_event(0, 1, 0, 1, 0, 64'h3ffc, 64'h4000, '0);
    tick();
    wait_idle(0);
    repeat (2) tick();

    // Randomised phase: random flags and random handshake timing, with
    // wrong-path commits while busy.
    for (int i = 0; i < 200; i++) begin
      drive_event($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, rnd64(), rnd64(), rnd64());
      tick();
      wait_idle(1);
    end
    auto_resp = 1'b0;
    clear_resp();
    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ysyx_cmu_redirect.md
Name: ysyx_cmu_redirect

Overview:
- Sits directly downstream of the commit unit and consumes its per-retire broadcast.
- When a retiring instruction needs the pipeline redirected, it sequences the whole recovery: a one-cycle pipeline flush, an optional D-cache drain and/or I-cache invalidate handshake, and a held redirect toward the IFU.
- Asserts commit_stall while recovery is in progress.
- Events handled: flush_pipe (mispredict/serialising), fence_i, fence_time, time_trap.

Parameters:
XLEN, `YSYX_XLEN, width of PCs and counters.

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
cmt_valid  in  1  an instruction retires this cycle
cmt_rpc  in  XLEN  retire PC
cmt_cpc  in  XLEN  correct next PC of the retiring instruction
cmt_flush_pipe  in  1  retiring instruction requires a pipeline flush and redirect to cmt_cpc
cmt_fence_i  in  1  retiring instruction is fence.i
cmt_fence_time  in  1  retiring instruction is a memory fence needing a D-cache drain
cmt_time_trap  in  1  timer trap pending (level; not gated by cmt_valid)
trap_vec  in  XLEN  trap vector PC
dc_drain_req  out  1  D-cache write-back/drain request
dc_drain_done  in  1  drain complete (pulse)
ic_inv_req  out  1  I-cache invalidate-all request
ic_inv_done  in  1  invalidate complete (pulse)
flush  out  1  one-cycle flush of all speculative state
redirect_valid  out  1  redirect request to IFU
redirect_pc  out  XLEN  redirect target
redirect_ready  in  1  IFU accepts redirect
commit_stall  out  1  recovery in progress; upstream ROB must not retire
trap_epc  out  XLEN  captured cmt_rpc for trap entry (valid while redirecting a trap)
pmu_redirect  out  XLEN  count of completed redirects
pmu_fence_i  out  XLEN  count of completed fence.i sequences

Behaviour:
- Registered FSM with states IDLE, FLUSH, DRAIN_DC, INV_IC, REDIRECT.
- Reset: state=IDLE and all outputs 0, including both counters, redirect_pc and trap_epc. A reset mid-sequence abandons any outstanding request; a late done pulse is then ignored.
- commit_stall = (state != IDLE). It is registered-state-derived, so it is high from the cycle after the triggering event.
- IDLE trigger, priority highest first:
  - cmt_time_trap (any cmt_valid): target=trap_vec, trap_epc=cmt_rpc, kind=TRAP.
  - cmt_valid && cmt_fence_i: target=cmt_cpc, kind=FENCEI.
  - cmt_valid && cmt_fence_time: target=cmt_cpc, kind=FENCE.
  - cmt_valid && cmt_flush_pipe: target=cmt_cpc, kind=FLUSH.
  - In every case the next state is FLUSH. Target and kind are latched and used for the rest of the sequence.
- cmt_valid with no event flags: no action.
- Any cmt_* input while state != IDLE is ignored, including time_trap. Those instructions are wrong-path and get flushed.
- FLUSH: flush=1 for exactly this cycle. Next state is DRAIN_DC for FENCEI/FENCE, otherwise REDIRECT.
- DRAIN_DC: dc_drain_req=1, held until dc_drain_done is sampled high. A done in the first DRAIN_DC cycle is accepted. Next state is INV_IC for FENCEI, otherwise REDIRECT.
- INV_IC: ic_inv_req=1 until ic_inv_done, same rules as DRAIN_DC. Next state is REDIRECT.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target; both stable until redirect_ready.
  - On redirect_valid && redirect_ready: pmu_redirect+=1, plus pmu_fence_i+=1 if kind=FENCEI; next state IDLE.
- done/ready pulses outside their state are ignored.
- Counters wrap modulo 2^XLEN.
- Minimum latency with ready/done tied high: event at T, flush at T+1, redirect_valid at T+2 (FLUSH/TRAP), T+3 (FENCE), T+4 (FENCEI). commit_stall returns to 0 the cycle after the handshake.
- A new event is accepted in the first IDLE cycle after completion.

Test Plan:
- Reset with all inputs high: all outputs 0 during reset and in the first cycle after release. Pre-reset count 3 → pmu_redirect=0.
- flush_pipe, ready stalled: cmt_valid=1, flush_pipe=1, cpc=0x80000040 at T, redirect_ready=0 until T+5 → flush only at T+1; redirect_valid=1 with pc 0x80000040 stable T+2..T+5; IDLE at T+6; pmu_redirect=1.
- fence_i sequence:
  - cpc=0x80000100; dc_drain_done at T+4, ic_inv_done same cycle ic_inv_req rises (T+5).
  - Required: dc_drain_req T+2..T+4; ic_inv_req at T+5 only; redirect at T+6.
  - pmu_fence_i=1; commit_stall high T+1..T+6.
- Simultaneous events: time_trap=1 with cmt_valid, fence_i=1, rpc=0x80000010, trap_vec=0x80001000 → no drain/invalidate; redirect_pc=0x80001000; trap_epc=0x80000010.
- Overlap: second flush_pipe commit (cpc=0x2000) at T+1 and T+2 during the first sequence (cpc=0x1000) → only one redirect to 0x1000; stray dc_drain_done/ic_inv_done pulses in IDLE have no effect.
- Reset mid-op: reset asserted while in DRAIN_DC → dc_drain_req=0 next cycle; later dc_drain_done causes no transition; a fresh fence_time completes normally.
